spi_master_cfg: RTL and testbench

- Parametrised SPI master; successor to the fixed divide-by-11 serial-RAM clock generator.
- Adds programmable SCLK divider, all four CPOL/CPHA modes, configurable word width, bit order and multiple chip selects.
- Full-duplex shift with start/busy/done handshake to a local controller.
- Sits between on-chip control logic and external serial RAM/flash/peripherals.

---
 rtl/spi_master_cfg.sv | 145 ++++++++++++++
 tb/tb_spi_master_cfg.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cfg.sv
// Parametrised SPI master: programmable SCLK divider, CPOL/CPHA modes, bit order,
// multiple chip selects, full-duplex shift with start/busy/done handshake.
module spi_master_cfg #(
    parameter int DATA_W    = 8,
    parameter int CS_N      = 1,
    parameter int DIV_W     = 16,
    parameter int LSB_FIRST = 0,
    parameter int SEL_W     = (CS_N > 1) ? $clog2(CS_N) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic [SEL_W-1:0]  cs_sel_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic [DIV_W-1:0]  div_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic [CS_N-1:0]   cs_n_o
);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    localparam int EW = $clog2(2 * DATA_W + 1);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, cnt_q;
    logic [EW-1:0]     edge_q, edge_nxt;
    logic              cpol_q, cpha_q;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic              tick, accept, last_edge, leading;
    logic [CS_N-1:0]   cs_dec;

    function automatic logic out_bit(input logic [DATA_W-1:0] s);
        return (LSB_FIRST != 0) ? s[0] : s[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] s);
        return (LSB_FIRST != 0) ? (s >> 1) : (s << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] s, input logic b);
        return (LSB_FIRST != 0) ? {b, s[DATA_W-1:1]} : {s[DATA_W-2:0], b};
    endfunction

    // Out-of-range selects decode to no asserted chip select.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < CS_N; i++) cs_dec[i] = (cs_sel_i != SEL_W'(i));
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        tick      = (cnt_q == div_q);
        edge_nxt  = edge_q + 1'b1;
        leading   = edge_nxt[0];
        last_edge = (edge_nxt == EW'(2 * DATA_W));
        case (state_q)
            IDLE:  if (start_i) begin
                       accept  = 1'b1;
                       state_d = SETUP;
                   end
            SETUP: if (tick) state_d = XFER;
            XFER:  if (tick && last_edge) state_d = HOLD;
            HOLD:  if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            rx_data_o <= '0;
            sclk_o    <= 1'b0;
            mosi_o    <= 1'b0;
            cs_n_o    <= '1;
            div_q     <= '0;
            cnt_q     <= '0;
            edge_q    <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            tx_sh     <= '0;
            rx_sh     <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_o <= cpol_i;
                    mosi_o <= 1'b0;
                    cnt_q  <= '0;
                    edge_q <= '0;
                    if (accept) begin
                        busy_o <= 1'b1;
                        div_q  <= div_i;
                        cpol_q <= cpol_i;
                        cpha_q <= cpha_i;
                        cs_n_o <= cs_dec;
                        rx_sh  <= '0;
                        // Mode 0/2 slaves sample on the first edge, so the first bit goes out now.
                        if (!cpha_i) begin
                            mosi_o <= out_bit(tx_data_i);
                            tx_sh  <= shift_tx(tx_data_i);
                        end else begin
                            tx_sh  <= tx_data_i;
                        end
                    end
                end
                default: begin
                    cnt_q <= tick ? '0 : cnt_q + 1'b1;
                    if (state_q == XFER && tick) begin
                        sclk_o <= ~sclk_o;
                        edge_q <= edge_nxt;
                        // Sample on leading edges when cpha=0, trailing edges when cpha=1.
                        if (leading ^ cpha_q) begin
                            rx_sh <= shift_rx(rx_sh, miso_i);
                        end else if (!last_edge) begin
                            mosi_o <= out_bit(tx_sh);
                            tx_sh  <= shift_tx(tx_sh);
                        end
                    end
                    if (state_q == HOLD && tick) begin
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                        cs_n_o    <= '1;
                        mosi_o    <= 1'b0;
                        rx_data_o <= rx_sh;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: an MSB-first single-CS instance and an LSB-first 4-CS
// instance run in lockstep against behavioural SPI slave models.
module tb_spi_master_cfg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  tx_i = '0;
    logic        sel_a = 1'b0;
    logic [2:0]  sel_b = '0;
    logic        cpol_i = 1'b0;
    logic        cpha_i = 1'b0;
    logic [15:0] div_i = '0;

    logic        busy_a, done_a, sclk_a, mosi_a, miso_a, cs_a;
    logic [7:0]  rx_a;
    logic        busy_b, done_b, sclk_b, mosi_b, miso_b;
    logic [7:0]  rx_b;
    logic [3:0]  cs_b;

    int pas = 0;
    int tot = 0;

    // slave-side state
    logic       m_pol = 1'b0, m_pha = 1'b0, loop_a = 1'b0;
    logic [7:0] sw_a = '0, sw_b = '0, cap_a = '0, cap_b = '0;
    logic       so_a = 1'b0, so_b = 1'b0, sp_a = 1'b0, sp_b = 1'b0;
    logic       fa = 1'b1, fb = 1'b1;
    int         ka_tx = 0, ka_rx = 0, kb_tx = 0, kb_rx = 0, rise_a = 0;

    assign miso_a = loop_a ? mosi_a : so_a;
    assign miso_b = so_b;

    spi_master_cfg #(.DATA_W(8), .CS_N(1), .DIV_W(16), .LSB_FIRST(0)) ua (
        .clk_i(clk), .rst_i(rst), .start_i(start), .tx_data_i(tx_i), .cs_sel_i(sel_a),
        .cpol_i(cpol_i), .cpha_i(cpha_i), .div_i(div_i), .busy_o(busy_a), .done_o(done_a),
        .rx_data_o(rx_a), .sclk_o(sclk_a), .mosi_o(mosi_a), .miso_i(miso_a), .cs_n_o(cs_a));

    spi_master_cfg #(.DATA_W(8), .CS_N(4), .DIV_W(16), .LSB_FIRST(1), .SEL_W(3)) ub (
        .clk_i(clk), .rst_i(rst), .start_i(start), .tx_data_i(tx_i), .cs_sel_i(sel_b),
        .cpol_i(cpol_i), .cpha_i(cpha_i), .div_i(div_i), .busy_o(busy_b), .done_o(done_b),
        .rx_data_o(rx_b), .sclk_o(sclk_b), .mosi_o(mosi_b), .miso_i(miso_b), .cs_n_o(cs_b));

    always #5 clk = ~clk;

    // MSB-first slave on instance A
    always @(negedge clk) begin
        if (cs_a) begin
            ka_tx = 0; ka_rx = 0; fa = 1'b1; so_a = 1'b0;
        end else if (fa) begin
            fa = 1'b0; cap_a = '0; rise_a = 0;
            if (!m_pha) begin so_a = sw_a[7-ka_tx]; ka_tx++; end
        end else if (sclk_a != sp_a) begin
            if (sclk_a) rise_a++;
            if ((sp_a == m_pol) ^ m_pha) begin
                if (ka_rx < 8) cap_a[7-ka_rx] = mosi_a;
                ka_rx++;
            end else if (ka_tx < 8) begin
                so_a = sw_a[7-ka_tx]; ka_tx++;
            end
        end
        sp_a = sclk_a;
    end

    // LSB-first slave on instance B, active whenever any select is low
    always @(negedge clk) begin
        if (cs_b == 4'hF) begin
            kb_tx = 0; kb_rx = 0; fb = 1'b1; so_b = 1'b0;
        end else if (fb) begin
            fb = 1'b0; cap_b = '0;
            if (!m_pha) begin so_b = sw_b[kb_tx]; kb_tx++; end
        end else if (sclk_b != sp_b) begin
            if ((sp_b == m_pol) ^ m_pha) begin
                if (kb_rx < 8) cap_b[kb_rx] = mosi_b;
                kb_rx++;
            end else if (kb_tx < 8) begin
                so_b = sw_b[kb_tx]; kb_tx++;
            end
        end
        sp_b = sclk_b;
    end

    task automatic run_xfer(input logic [7:0] tx, input logic [2:0] sel, input logic [15:0] dv,
                            input logic pol, input logic pha, output int bcyc, output int dcnt,
                            output int dcnt_b, output logic [3:0] csb0, output logic csa0,
                            output logic ma0, output logic mb0);
        @(negedge clk);
        tx_i = tx; sel_b = sel; div_i = dv; cpol_i = pol; cpha_i = pha;
        m_pol = pol; m_pha = pha; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        csb0 = cs_b; csa0 = cs_a; ma0 = mosi_a; mb0 = mosi_b;
        cpol_i = 1'($urandom); cpha_i = 1'($urandom); div_i = 16'($urandom); tx_i = 8'($urandom);
        bcyc = 0; dcnt = 0; dcnt_b = 0;
        while (busy_a === 1'b1 && bcyc < 3000) begin
            bcyc++;
            if (done_a) dcnt++;
            if (done_b) dcnt_b++;
            @(negedge clk);
        end
        cpol_i = pol;
        if (done_a) dcnt++;
        if (done_b) dcnt_b++;
        @(negedge clk);
        if (done_a) dcnt++;
        if (done_b) dcnt_b++;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpol_i = 1'b1;
        repeat (3) @(negedge clk);
        tot++; if ({busy_a, done_a, busy_b, done_b} !== 4'b0) $display("FAIL rst_busy_done got %b want 0000", {busy_a, done_a, busy_b, done_b}); else pas++;
        tot++; if ({rx_a, rx_b} !== 16'h0) $display("FAIL rst_rx got %h want 0000", {rx_a, rx_b}); else pas++;
        tot++; if ({sclk_a, mosi_a, sclk_b, mosi_b} !== 4'b0) $display("FAIL rst_sclk_mosi got %b want 0000", {sclk_a, mosi_a, sclk_b, mosi_b}); else pas++;
        tot++; if ({cs_a, cs_b} !== 5'h1F) $display("FAIL rst_cs got %h want 1f", {cs_a, cs_b}); else pas++;
        rst = 1'b0; cpol_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback();
        int bc, dc, dcb; logic [3:0] c4; logic c1, m1, m2;
        loop_a = 1'b1; sw_b = 8'h00;
        run_xfer(8'hA5, 3'd0, 16'd1, 1'b0, 1'b0, bc, dc, dcb, c4, c1, m1, m2);
        tot++; if (bc !== 36) $display("FAIL loop_busy got %0d want 36", bc); else pas++;
        tot++; if (dc !== 1) $display("FAIL loop_done got %0d want 1", dc); else pas++;
        tot++; if (rx_a !== 8'hA5) $display("FAIL loop_rx got %h want a5", rx_a); else pas++;
        tot++; if (rise_a !== 8) $display("FAIL loop_rises got %0d want 8", rise_a); else pas++;
        tot++; if (sclk_a !== 1'b0) $display("FAIL loop_idle got %b want 0", sclk_a); else pas++;
        loop_a = 1'b0;
    endtask

    task automatic test_modes();
        int bc, dc, dcb, dv; logic [3:0] c4; logic c1, m1, m2, pol, pha;
        for (int m = 0; m < 4; m++) begin
            pol = 1'(m >> 1); pha = 1'(m);
            dv = int'($urandom_range(0, 2));
            sw_a = 8'h3C; sw_b = 8'h3C;
            run_xfer(8'hC3, 3'd1, 16'(dv), pol, pha, bc, dc, dcb, c4, c1, m1, m2);
            tot++; if ({rx_a, rx_b} !== 16'h3C3C) $display("FAIL mode%0d_rx got %h want 3c3c", m, {rx_a, rx_b}); else pas++;
            tot++; if ({cap_a, cap_b} !== 16'hC3C3) $display("FAIL mode%0d_cap got %h want c3c3", m, {cap_a, cap_b}); else pas++;
            tot++; if (sclk_a !== pol || sclk_b !== pol) $display("FAIL mode%0d_idle got %b%b want %b", m, sclk_a, sclk_b, pol); else pas++;
            tot++; if (bc !== 18 * (dv + 1)) $display("FAIL mode%0d_busy got %0d want %0d", m, bc, 18 * (dv + 1)); else pas++;
            tot++; if (c4 !== 4'b1101) $display("FAIL mode%0d_cs got %b want 1101", m, c4); else pas++;
        end
    endtask

    task automatic test_divider();
        int bc, dc, dcb; logic [3:0] c4; logic c1, m1, m2;
        sw_a = 8'h81; sw_b = 8'h18;
        run_xfer(8'h7E, 3'd0, 16'd0, 1'b0, 1'b0, bc, dc, dcb, c4, c1, m1, m2);
        tot++; if (bc !== 18) $display("FAIL div0_busy got %0d want 18", bc); else pas++;
        tot++; if (rise_a !== 8 || rx_a !== 8'h81) $display("FAIL div0_data got %0d/%h want 8/81", rise_a, rx_a); else pas++;
        run_xfer(8'h7E, 3'd3, 16'd10, 1'b1, 1'b1, bc, dc, dcb, c4, c1, m1, m2);
        tot++; if (bc !== 198) $display("FAIL div10_busy got %0d want 198", bc); else pas++;
        tot++; if ({rx_a, rx_b} !== 16'h8118) $display("FAIL div10_rx got %h want 8118", {rx_a, rx_b}); else pas++;
    endtask

    task automatic test_multi_cs();
        int bc, dc, dcb; logic [3:0] c4; logic c1, m1, m2;
        sw_a = 8'h44; sw_b = 8'h99;
        run_xfer(8'h01, 3'd2, 16'd1, 1'b0, 1'b0, bc, dc, dcb, c4, c1, m1, m2);
        tot++; if (c4 !== 4'b1011 || c1 !== 1'b0) $display("FAIL cs2_sel got %b/%b want 1011/0", c4, c1); else pas++;
        tot++; if ({m1, m2} !== 2'b01) $display("FAIL first_bit got %b want 01", {m1, m2}); else pas++;
        tot++; if (cap_b !== 8'h01 || rx_b !== 8'h99) $display("FAIL cs2_data got %h/%h want 01/99", cap_b, rx_b); else pas++;
        run_xfer(8'h5A, 3'd5, 16'd1, 1'b0, 1'b1, bc, dc, dcb, c4, c1, m1, m2);
        tot++; if (c4 !== 4'hF) $display("FAIL cs5_none got %h want f", c4); else pas++;
        tot++; if (dcb !== 1 || rx_b !== 8'h00) $display("FAIL cs5_done got %0d/%h want 1/00", dcb, rx_b); else pas++;
        tot++; if (rx_a !== 8'h44) $display("FAIL cs5_rx_a got %h want 44", rx_a); else pas++;
    endtask

    task automatic test_random();
        int bc, dc, dcb, dv; logic [3:0] c4, ecs; logic c1, m1, m2, pol, pha;
        logic [7:0] tx; logic [2:0] sel;
        for (int it = 0; it < 8; it++) begin
            tx = 8'($urandom); sw_a = 8'($urandom); sw_b = 8'($urandom);
            sel = 3'($urandom_range(0, 5)); dv = int'($urandom_range(0, 3));
            pol = 1'($urandom); pha = 1'($urandom);
            run_xfer(tx, sel, 16'(dv), pol, pha, bc, dc, dcb, c4, c1, m1, m2);
            ecs = 4'hF;
            if (sel < 3'd4) ecs[sel[1:0]] = 1'b0;
            tot++; if (rx_a !== sw_a || cap_a !== tx) $display("FAIL rnd%0d_a got %h/%h want %h/%h", it, rx_a, cap_a, sw_a, tx); else pas++;
            tot++; if (rx_b !== ((sel < 3'd4) ? sw_b : 8'h00)) $display("FAIL rnd%0d_rxb got %h sel %0d", it, rx_b, sel); else pas++;
            if (sel < 3'd4) begin
                tot++; if (cap_b !== tx) $display("FAIL rnd%0d_capb got %h want %h", it, cap_b, tx); else pas++;
            end
            tot++; if (c4 !== ecs) $display("FAIL rnd%0d_cs got %b want %b", it, c4, ecs); else pas++;
            tot++; if (bc !== 18 * (dv + 1) || dc !== 1) $display("FAIL rnd%0d_timing got %0d/%0d want %0d/1", it, bc, dc, 18 * (dv + 1)); else pas++;
        end
    endtask

    task automatic test_back_to_back();
        int w;
        @(negedge clk);
        sw_a = 8'h5A; m_pol = 1'b0; m_pha = 1'b0; cpol_i = 1'b0; cpha_i = 1'b0;
        div_i = 16'd0; tx_i = 8'h96; sel_b = 3'd0; start = 1'b1;
        w = 0;
        while (done_a !== 1'b1 && w < 200) begin w++; @(negedge clk); end
        tot++; if (done_a !== 1'b1 || cs_a !== 1'b1 || cap_a !== 8'h96) $display("FAIL b2b_first got done %b cs %b cap %h want 1/1/96", done_a, cs_a, cap_a); else pas++;
        tx_i = 8'h69;
        @(negedge clk);
        tot++; if (busy_a !== 1'b1 || cs_a !== 1'b0) $display("FAIL b2b_accept got busy %b cs %b want 1/0", busy_a, cs_a); else pas++;
        start = 1'b0;
        w = 0;
        while (done_a !== 1'b1 && w < 200) begin w++; @(negedge clk); end
        tot++; if (done_a !== 1'b1 || rx_a !== 8'h5A || cap_a !== 8'h69) $display("FAIL b2b_second got done %b rx %h cap %h want 1/5a/69", done_a, rx_a, cap_a); else pas++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ignore();
        int dn;
        @(negedge clk);
        tx_i = 8'h33; sel_b = 3'd0; div_i = 16'd1; cpol_i = 1'b0; cpha_i = 1'b0;
        m_pol = 1'b0; m_pha = 1'b0; sw_a = 8'hE7; start = 1'b1;
        @(negedge clk); start = 1'b0; dn = 0;
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (done_a) dn++;
            @(negedge clk);
        end
        tot++; if (dn !== 1 || busy_a !== 1'b0) $display("FAIL ignore_start got %0d dones busy %b want 1/0", dn, busy_a); else pas++;
        tot++; if (rx_a !== 8'hE7) $display("FAIL ignore_rx got %h want e7", rx_a); else pas++;
    endtask

    task automatic test_reset_mid();
        int bc, dc, dcb, dn; logic [3:0] c4; logic c1, m1, m2;
        @(negedge clk);
        tx_i = 8'hF0; sel_b = 3'd1; div_i = 16'd1; cpol_i = 1'b0; cpha_i = 1'b0;
        m_pol = 1'b0; m_pha = 1'b0; sw_a = 8'h0F; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tot++; if ({busy_a, busy_b, done_a, done_b} !== 4'b0) $display("FAIL rstmid_busy got %b want 0000", {busy_a, busy_b, done_a, done_b}); else pas++;
        tot++; if ({cs_a, cs_b} !== 5'h1F || rx_a !== 8'h00) $display("FAIL rstmid_cs got %h rx %h want 1f/00", {cs_a, cs_b}, rx_a); else pas++;
        dn = 0;
        for (int i = 0; i < 60; i++) begin
            if (done_a || done_b) dn++;
            @(negedge clk);
        end
        tot++; if (dn !== 0) $display("FAIL rstmid_nodone got %0d want 0", dn); else pas++;
        sw_a = 8'hC9;
        run_xfer(8'h1E, 3'd1, 16'd1, 1'b0, 1'b0, bc, dc, dcb, c4, c1, m1, m2);
        tot++; if (rx_a !== 8'hC9 || cap_a !== 8'h1E || bc !== 36) $display("FAIL rstmid_after got %h/%h/%0d want c9/1e/36", rx_a, cap_a, bc); else pas++;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_modes();
        test_divider();
        test_multi_cs();
        test_random();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", pas, tot);
        $finish;
    end

endmodule
